// File: rtl/cache_ctrl_pkg.sv
// Shared types and select-encoding constants for the cache controller.
// Included by cache_control and its optional performance-counter block.
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } cache_state_e;

    localparam logic WAY_SEL_HIT   = 1'b0;
    localparam logic WAY_SEL_LRU   = 1'b1;
    localparam logic LINE_SRC_PMEM = 1'b0;
    localparam logic LINE_SRC_CPU  = 1'b1;
    localparam logic ADDR_SRC_CPU  = 1'b0;
    localparam logic ADDR_SRC_WB   = 1'b1;

endpackage

// File: rtl/cache_control_if.sv
// CPU, physical-memory and datapath-strobe signals of the cache controller.
// The controller connects through the master modport; its environment through slave.
interface cache_control_if;

    logic mem_read;
    logic mem_write;
    logic mem_resp;
    logic pmem_read;
    logic pmem_write;
    logic pmem_resp;
    logic hit;
    logic dirty;
    logic valid;
    logic way_sel_method;
    logic load_line_data;
    logic line_datain_sel;
    logic load_valid;
    logic valid_in;
    logic load_dirty;
    logic dirty_in;
    logic load_LRU;
    logic load_wdata_reg;
    logic address_sel;

    modport master (
        input  mem_read, mem_write, pmem_resp, hit, dirty, valid,
        output mem_resp, pmem_read, pmem_write, way_sel_method, load_line_data,
               line_datain_sel, load_valid, valid_in, load_dirty, dirty_in,
               load_LRU, load_wdata_reg, address_sel
    );

    modport slave (
        output mem_read, mem_write, pmem_resp, hit, dirty, valid,
        input  mem_resp, pmem_read, pmem_write, way_sel_method, load_line_data,
               line_datain_sel, load_valid, valid_in, load_dirty, dirty_in,
               load_LRU, load_wdata_reg, address_sel
    );

endinterface

// File: rtl/cache_perf_counters.sv
// Saturating hit / miss / writeback event counters for the cache controller.
// Only instantiated when CACHE_CTRL_PERF_EN is defined.
module cache_perf_counters #(
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc_hit,
    input  logic                  inc_miss,
    input  logic                  inc_wb,
    output logic [PERF_CNT_W-1:0] hit_count,
    output logic [PERF_CNT_W-1:0] miss_count,
    output logic [PERF_CNT_W-1:0] wb_count
);

    logic [2:0]            inc;
    logic [PERF_CNT_W-1:0] cnt_q [3];
    logic [PERF_CNT_W-1:0] cnt_d [3];

    assign inc = {inc_wb, inc_miss, inc_hit};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            // Hold at all-ones instead of wrapping back to zero.
            always_comb begin
                cnt_d[gi] = cnt_q[gi];
                if (inc[gi] && (cnt_q[gi] != {PERF_CNT_W{1'b1}}))
                    cnt_d[gi] = cnt_q[gi] + 1'b1;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt_q[gi] <= '0;
                else        cnt_q[gi] <= cnt_d[gi];
            end
        end
    endgenerate

    assign hit_count  = cnt_q[0];
    assign miss_count = cnt_q[1];
    assign wb_count   = cnt_q[2];

endmodule

// File: rtl/cache_control.sv
// Control FSM for the 2-way write-back, write-allocate cache datapath.
// Define CACHE_CTRL_PERF_EN to add saturating hit/miss/writeback counters.
module cache_control
    import cache_ctrl_pkg::*;
`ifdef CACHE_CTRL_PERF_EN
#(
    parameter int PERF_CNT_W = 32
)
`endif
(
    input  logic               clk,
    input  logic               rst_n,
`ifdef CACHE_CTRL_PERF_EN
    output logic [PERF_CNT_W-1:0] hit_count,
    output logic [PERF_CNT_W-1:0] miss_count,
    output logic [PERF_CNT_W-1:0] wb_count,
`endif
    cache_control_if.master    bus
);

    cache_state_e state_q, state_d;
    logic         req;

    assign req = bus.mem_read | bus.mem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d             = state_q;
        bus.mem_resp        = 1'b0;
        bus.pmem_read       = 1'b0;
        bus.pmem_write      = 1'b0;
        bus.way_sel_method  = WAY_SEL_HIT;
        bus.load_line_data  = 1'b0;
        bus.line_datain_sel = LINE_SRC_PMEM;
        bus.load_valid      = 1'b0;
        bus.valid_in        = 1'b0;
        bus.load_dirty      = 1'b0;
        bus.dirty_in        = 1'b0;
        bus.load_LRU        = 1'b0;
        bus.load_wdata_reg  = 1'b0;
        bus.address_sel     = ADDR_SRC_CPU;

        unique case (state_q)
            IDLE: begin
                if (req) state_d = CHECK;
            end

            CHECK: begin
                // A request withdrawn during a miss retires silently here.
                if (!req) begin
                    state_d = IDLE;
                end else if (bus.hit) begin
                    bus.way_sel_method = WAY_SEL_HIT;
                    bus.load_LRU       = 1'b1;
                    bus.mem_resp       = 1'b1;
                    if (bus.mem_write) begin
                        bus.load_line_data  = 1'b1;
                        bus.line_datain_sel = LINE_SRC_CPU;
                        bus.load_dirty      = 1'b1;
                        bus.dirty_in        = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    bus.way_sel_method = WAY_SEL_LRU;
                    if (bus.dirty) begin
                        bus.load_wdata_reg = 1'b1;
                        state_d            = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end

            WRITEBACK: begin
                bus.way_sel_method = WAY_SEL_LRU;
                bus.address_sel    = ADDR_SRC_WB;
                bus.pmem_write     = 1'b1;
                if (bus.pmem_resp) state_d = ALLOCATE;
            end

            ALLOCATE: begin
                bus.way_sel_method = WAY_SEL_LRU;
                bus.address_sel    = ADDR_SRC_CPU;
                bus.pmem_read      = 1'b1;
                if (bus.pmem_resp) begin
                    bus.load_line_data  = 1'b1;
                    bus.line_datain_sel = LINE_SRC_PMEM;
                    bus.load_valid      = 1'b1;
                    bus.valid_in        = 1'b1;
                    bus.load_dirty      = 1'b1;
                    bus.dirty_in        = 1'b0;
                    state_d             = CHECK;
                end
            end

            default: state_d = IDLE;
        endcase
    end

`ifdef CACHE_CTRL_PERF_EN
    logic inc_hit, inc_miss, inc_wb;

    assign inc_hit  = (state_q == CHECK) && bus.hit && bus.mem_resp;
    assign inc_miss = (state_q == CHECK) && ((state_d == WRITEBACK) || (state_d == ALLOCATE));
    assign inc_wb   = (state_q == CHECK) && (state_d == WRITEBACK);

    cache_perf_counters #(
        .PERF_CNT_W (PERF_CNT_W)
    ) u_perf (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_hit    (inc_hit),
        .inc_miss   (inc_miss),
        .inc_wb     (inc_wb),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: each step queues the expected strobe vector
// and compares it against the DUT outputs on the falling edge.
module tb_cache_control;
    import cache_ctrl_pkg::*;

    logic clk;
    logic rst_n;

    cache_control_if bus ();

`ifdef CACHE_CTRL_PERF_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    cache_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef CACHE_CTRL_PERF_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_resp, pmem_read, pmem_write, way_sel_method, load_line_data,
    //  line_datain_sel, load_valid, valid_in, load_dirty, dirty_in,
    //  load_LRU, load_wdata_reg, address_sel}
    localparam logic [12:0] O_NONE = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] O_RHIT = 13'b1_0_0_0_0_0_0_0_0_0_1_0_0;
    localparam logic [12:0] O_WHIT = 13'b1_0_0_0_1_1_0_0_1_1_1_0_0;
    localparam logic [12:0] O_MC   = 13'b0_0_0_1_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] O_MD   = 13'b0_0_0_1_0_0_0_0_0_0_0_1_0;
    localparam logic [12:0] O_WB   = 13'b0_0_1_1_0_0_0_0_0_0_0_0_1;
    localparam logic [12:0] O_AL   = 13'b0_1_0_1_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] O_ALR  = 13'b0_1_0_1_1_0_1_1_1_0_0_0_0;

    logic [12:0] exp_q [$];
    string       tag_q [$];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [12:0] observed();
        return {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.way_sel_method,
                bus.load_line_data, bus.line_datain_sel, bus.load_valid, bus.valid_in,
                bus.load_dirty, bus.dirty_in, bus.load_LRU, bus.load_wdata_reg,
                bus.address_sel};
    endfunction

    task automatic check_now();
        logic [12:0] e;
        logic [12:0] o;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observed();
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", t, o, e);
        end
        $display("step %-14s observed=%b expected=%b", t, o, e);
    endtask

    // Drive inputs for one cycle, compare on the falling edge, advance past the rising edge.
    task automatic step(input logic rd, input logic wr, input logic h, input logic d,
                        input logic pr, input logic [12:0] e, input string t);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.hit       = h;
        bus.dirty     = d;
        bus.pmem_resp = pr;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef CACHE_CTRL_PERF_EN
        logic [31:0] hc0;
`endif
        rst_n         = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.hit       = 1'b0;
        bus.dirty     = 1'b0;
        bus.valid     = 1'b0;
        bus.pmem_resp = 1'b0;

        // Reset: outputs low even with a request present, and the cycle after release.
        step(1, 0, 1, 0, 0, O_NONE, "rst_hold");
        step(1, 0, 1, 0, 0, O_NONE, "rst_hold2");
        rst_n = 1'b1;
        step(1, 0, 1, 0, 0, O_NONE, "rst_release");
        step(1, 0, 1, 0, 0, O_RHIT, "rd_hit_after_rst");
        step(0, 0, 0, 0, 0, O_NONE, "idle0");

        // Read hit
        bus.valid = 1'b1;
        step(1, 0, 1, 0, 0, O_NONE, "rd_hit_idle");
        step(1, 0, 1, 0, 0, O_RHIT, "rd_hit_check");
        step(0, 0, 0, 0, 0, O_NONE, "rd_hit_done");

        // Write hit
        step(0, 1, 1, 0, 0, O_NONE, "wr_hit_idle");
        step(0, 1, 1, 0, 0, O_WHIT, "wr_hit_check");
        step(0, 0, 0, 0, 0, O_NONE, "wr_hit_done");

        // Read and write together on a hit take the write path
`ifdef CACHE_CTRL_PERF_EN
        hc0 = hit_count;
`endif
        step(1, 1, 1, 0, 0, O_NONE, "rw_hit_idle");
        step(1, 1, 1, 0, 0, O_WHIT, "rw_hit_check");
        step(0, 0, 0, 0, 0, O_NONE, "rw_hit_done");
`ifdef CACHE_CTRL_PERF_EN
        total++;
        assert (hit_count === hc0 + 32'd1) else begin
            bad++;
            $error("FAIL hit_count observed=%0d expected=%0d", hit_count, hc0 + 32'd1);
        end
`endif

        // Clean miss: pmem_read held five cycles, fill, then re-check hits
        step(1, 0, 0, 0, 0, O_NONE, "cm_idle");
        step(1, 0, 0, 0, 0, O_MC,   "cm_check");
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 0, 0, O_AL, "cm_alloc_wait");
        step(1, 0, 0, 0, 1, O_ALR,  "cm_alloc_resp");
        step(1, 0, 1, 0, 0, O_RHIT, "cm_recheck");
        step(0, 0, 0, 0, 0, O_NONE, "cm_done");

        // Dirty miss: capture victim, writeback, fill, then complete
        step(0, 1, 0, 1, 0, O_NONE, "dm_idle");
        step(0, 1, 0, 1, 0, O_MD,   "dm_check");
        step(0, 1, 0, 1, 0, O_WB,   "dm_wb_wait");
        step(0, 1, 0, 1, 0, O_WB,   "dm_wb_wait2");
        step(0, 1, 0, 1, 1, O_WB,   "dm_wb_resp");
        step(0, 1, 0, 0, 0, O_AL,   "dm_alloc_wait");
        step(0, 1, 0, 0, 1, O_ALR,  "dm_alloc_resp");
        step(0, 1, 1, 0, 0, O_WHIT, "dm_recheck");
        step(0, 0, 0, 0, 0, O_NONE, "dm_done");

        // Stray pmem_resp in IDLE changes nothing
        step(0, 0, 0, 0, 1, O_NONE, "stray_idle");
        step(0, 0, 0, 0, 0, O_NONE, "stray_idle2");

        // Request withdrawn during a miss: fill completes, CHECK retires without mem_resp
        step(1, 0, 0, 0, 0, O_NONE, "drop_idle");
        step(1, 0, 0, 0, 0, O_MC,   "drop_check");
        step(0, 0, 0, 0, 0, O_AL,   "drop_alloc");
        step(0, 0, 0, 0, 1, O_ALR,  "drop_alloc_resp");
        step(0, 0, 1, 0, 0, O_NONE, "drop_recheck");
        step(1, 0, 1, 0, 0, O_NONE, "drop_back_idle");
        step(1, 0, 1, 0, 0, O_RHIT, "drop_next_hit");
        step(0, 0, 0, 0, 0, O_NONE, "drop_done");

        // Reset asserted mid-ALLOCATE drops pmem_read without a clock edge
        step(1, 0, 0, 0, 0, O_NONE, "ra_idle");
        step(1, 0, 0, 0, 0, O_MC,   "ra_check");
        step(1, 0, 0, 0, 0, O_AL,   "ra_alloc");
        rst_n = 1'b0;
        #1;
        exp_q.push_back(O_NONE);
        tag_q.push_back("ra_async");
        check_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 1, O_NONE, "ra_stray_resp");
        step(0, 0, 0, 0, 1, O_NONE, "ra_stray_resp2");
        step(0, 0, 0, 0, 0, O_NONE, "ra_idle_after");

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
